wb_arbiter: RTL

Write-side companion to the core's 32×32 register file: it owns the single regfile write port and merges single-cycle ALU results with long-latency load/store writebacks. A 32-bit busy scoreboard tracks registers with an outstanding long-latency write and stalls decode on read-after-write and write-after-write hazards. It sits between the execute/LSU stages and the regfile, which commits writes on the falling clock edge.

---
 rtl/wb_pkg.sv | 10 +
 rtl/wb_arbiter_if.sv | 18 +
 rtl/wb_fifo.sv | 35 +++
 rtl/wb_arbiter.sv | 71 +++++++
 4 files changed

// File: rtl/wb_pkg.sv
// wb_pkg: shared widths and types for the regfile writeback arbiter
package wb_pkg;
    localparam int REG_AW = 5;
    localparam int XLEN = 32;
    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_req_t;
    typedef logic [31:0] sb_vec_t;
endpackage

// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if: decode, execute/LSU and regfile-port signals of the writeback arbiter
interface wb_arbiter_if;
    import wb_pkg::*;
    logic [REG_AW-1:0] i_rs1_addr, i_rs2_addr, i_iss_rd, i_alu_rd, i_lsu_rd, o_rd_addr;
    logic              i_iss_valid, i_iss_long, i_alu_valid, i_lsu_valid;
    logic              o_lsu_ready, o_rd_wren, o_stall, o_sb_err;
    logic [XLEN-1:0]   i_alu_data, i_lsu_data, o_rd_data;
    modport slave (
        input  i_rs1_addr, i_rs2_addr, i_iss_valid, i_iss_rd, i_iss_long,
        input  i_alu_valid, i_alu_rd, i_alu_data, i_lsu_valid, i_lsu_rd, i_lsu_data,
        output o_lsu_ready, o_rd_wren, o_rd_addr, o_rd_data, o_stall, o_sb_err
    );
    modport master (
        output i_rs1_addr, i_rs2_addr, i_iss_valid, i_iss_rd, i_iss_long,
        output i_alu_valid, i_alu_rd, i_alu_data, i_lsu_valid, i_lsu_rd, i_lsu_data,
        input  o_lsu_ready, o_rd_wren, o_rd_addr, o_rd_data, o_stall, o_sb_err
    );
endinterface

// File: rtl/wb_fifo.sv
// wb_fifo: power-of-two FIFO of writeback requests, flushed by reset
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    i_clk,
    input  logic    i_rst_n,
    input  logic    i_push,
    input  wb_req_t i_data,
    input  logic    i_pop,
    output logic    o_full,
    output logic    o_empty,
    output wb_req_t o_head
);
    localparam int AW = $clog2(DEPTH);
    wb_req_t     mem_q [DEPTH];
    logic [AW:0] wr_q, rd_q;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (i_push) wr_q <= wr_q + (AW+1)'(1);
            if (i_pop) rd_q <= rd_q + (AW+1)'(1);
        end
    end
    // storage needs no reset: pointers alone define what is valid
    always_ff @(posedge i_clk) begin
        if (i_push) mem_q[wr_q[AW-1:0]] <= i_data;
    end
    assign o_empty = wr_q == rd_q;
    assign o_full  = (wr_q ^ rd_q) == {1'b1, {AW{1'b0}}};
    assign o_head  = mem_q[rd_q[AW-1:0]];
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: owns the regfile write port, merging ALU and LSU writebacks
// and tracking long-latency destinations in a busy scoreboard.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input logic         i_clk,
    input logic         i_rst_n,
    wb_arbiter_if.slave bus
);
    logic              alu_win, pop, pop_wr, push, full, empty, stall, iss_set;
    logic              wren_q, wren_d, err_q, err_d;
    logic [REG_AW-1:0] addr_q, addr_d;
    logic [XLEN-1:0]   data_q, data_d;
    wb_req_t           head;
    sb_vec_t           busy_q, busy_d, clr_mask, set_mask;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (push),
        .i_data  ({bus.i_lsu_rd, bus.i_lsu_data}),
        .i_pop   (pop),
        .o_full  (full),
        .o_empty (empty),
        .o_head  (head)
    );

    always_comb begin
        alu_win  = bus.i_alu_valid && bus.i_alu_rd != '0;
        pop      = !alu_win && !empty;
        pop_wr   = pop && head.rd != '0;
        push     = bus.i_lsu_valid && !full;
        stall    = bus.i_iss_valid && (busy_q[bus.i_rs1_addr] || busy_q[bus.i_rs2_addr] || busy_q[bus.i_iss_rd]);
        iss_set  = bus.i_iss_valid && !stall && bus.i_iss_long && bus.i_iss_rd != '0;
        clr_mask = '0;
        set_mask = '0;
        if (pop_wr) clr_mask[head.rd] = 1'b1;
        if (iss_set) set_mask[bus.i_iss_rd] = 1'b1;
        // set is applied after clear so a same-cycle reissue keeps the register busy
        busy_d   = ((busy_q & ~clr_mask) | set_mask) & ~sb_vec_t'(1);
        wren_d   = alu_win || pop_wr;
        addr_d   = alu_win ? bus.i_alu_rd : pop_wr ? head.rd : '0;
        data_d   = alu_win ? bus.i_alu_data : pop_wr ? head.data : '0;
        err_d    = err_q || (pop_wr && !busy_q[head.rd]);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            busy_q <= '0;
            wren_q <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            err_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            wren_q <= wren_d;
            addr_q <= addr_d;
            data_q <= data_d;
            err_q  <= err_d;
        end
    end

    assign bus.o_lsu_ready = !full;
    assign bus.o_rd_wren   = wren_q;
    assign bus.o_rd_addr   = addr_q;
    assign bus.o_rd_data   = data_q;
    assign bus.o_stall     = stall;
    assign bus.o_sb_err    = err_q;
endmodule
